// File: rtl/led_blink_sequencer.sv
// Four-step LED pattern sequencer: a register port loads mask/duration steps and
// a control word, then the table is played out on a prescaled tick.
module led_blink_sequencer #(
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 12
) (
  input  logic        FAB_CLK,
  input  logic        FAB_LOCK,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_err,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        done,
  output logic        LED1,
  output logic        LED2,
  output logic        LED3,
  output logic        LED4
);

  localparam int                PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_mask [4];
  logic [DUR_W-1:0] r_dur  [4];
  logic [1:0]       r_last;
  logic             r_loop;

  logic [PW-1:0]    r_presc;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [1:0]       r_index;
  logic [3:0]       r_led;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;

  logic             w_tick;
  logic             w_expire;
  logic             w_load;
  logic [1:0]       w_load_idx;
  logic             w_go_idle;
  logic             w_finish;
  logic             w_wr_step;
  logic             w_wr_ctrl;
  logic             w_wr_bad;
  logic             w_unused_wdata;

  // A zero duration still shows the step for one full tick.
  function automatic logic [DUR_W-1:0] dur_floor1(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_ONE : d;
  endfunction

  assign w_tick    = (r_state == S_RUN) && (r_presc == PRE_LAST);
  assign w_expire  = w_tick && (r_dur_cnt <= DUR_ONE);
  assign w_wr_step = cfg_wr && !cfg_addr[2];
  assign w_wr_ctrl = cfg_wr && (cfg_addr == 3'd4) && !r_busy;
  assign w_wr_bad  = cfg_wr && cfg_addr[2] && ((cfg_addr[1:0] != 2'd0) || r_busy);
  assign w_unused_wdata = ^cfg_wdata;

  always_ff @(posedge FAB_CLK or negedge FAB_LOCK) begin
    if (!FAB_LOCK) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = 2'd0;
    w_go_idle   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        // stop outranks a step expiring in the same cycle
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_go_idle   = 1'b1;
        end else if (w_expire) begin
          if (r_index != r_last) begin
            w_load     = 1'b1;
            w_load_idx = r_index + 2'd1;
          end else if (r_loop) begin
            w_load     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_go_idle   = 1'b1;
            w_finish    = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge FAB_LOCK) begin
    if (!FAB_LOCK) begin
      for (int i = 0; i < 4; i++) begin
        r_mask[i] <= '0;
        r_dur[i]  <= '0;
      end
      r_last    <= '0;
      r_loop    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      if (w_wr_step) begin
        r_mask[cfg_addr[1:0]] <= cfg_wdata[15:12];
        r_dur[cfg_addr[1:0]]  <= cfg_wdata[DUR_W-1:0];
      end
      if (w_wr_ctrl) begin
        r_last <= cfg_wdata[1:0];
        r_loop <= cfg_wdata[2];
      end
      r_cfg_err <= w_wr_bad;
    end
  end

  // Step loads read the table before any same-cycle write lands.
  always_ff @(posedge FAB_CLK or negedge FAB_LOCK) begin
    if (!FAB_LOCK) begin
      r_presc   <= '0;
      r_dur_cnt <= '0;
      r_index   <= '0;
      r_led     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_go_idle) begin
        r_presc   <= '0;
        r_dur_cnt <= '0;
        r_index   <= '0;
        r_led     <= '0;
      end else if (w_load) begin
        r_presc   <= '0;
        r_dur_cnt <= dur_floor1(r_dur[w_load_idx]);
        r_index   <= w_load_idx;
        r_led     <= r_mask[w_load_idx];
      end else if (r_state == S_RUN) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) r_dur_cnt <= r_dur_cnt - DUR_ONE;
      end
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= w_finish;
    end
  end

  assign {LED4, LED3, LED2, LED1} = r_led;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with TICK_DIV=4; expected
// {busy,done,LED4..LED1} sequences are hand-derived cycle by cycle.
module tb_led_blink_sequencer;

  logic        FAB_CLK = 1'b0;
  logic        FAB_LOCK;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_err;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic        LED1, LED2, LED3, LED4;

  int n_total = 0;
  int n_bad   = 0;

  led_blink_sequencer #(.TICK_DIV(4), .DUR_W(12)) dut (
    .FAB_CLK  (FAB_CLK),
    .FAB_LOCK (FAB_LOCK),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_err  (cfg_err),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .done     (done),
    .LED1     (LED1),
    .LED2     (LED2),
    .LED3     (LED3),
    .LED4     (LED4)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [5:0] status();
    return {busy, done, LED4, LED3, LED2, LED1};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
  endtask

  // Expected status for the 3-step table {0001 x2, 0010 x1, 1100 x3} at cycle N+k.
  function automatic logic [5:0] basic_exp(input int k, input logic looping);
    int m;
    m = looping ? ((k - 1) % 24) + 1 : k;
    if (!looping && k >= 25) return (k == 25) ? 6'b01_0000 : 6'b00_0000;
    if (m <= 8)  return 6'b10_0001;
    if (m <= 12) return 6'b10_0010;
    return 6'b10_1100;
  endfunction

  initial begin
    FAB_LOCK  = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    start     = 1'b0;
    stop      = 1'b0;

    tick();
    check_val("reset_status", 32'(status()), 32'h0);
    check_val("reset_cfg_err", 32'(cfg_err), 32'h0);
    FAB_LOCK = 1'b1;
    tick();

    // Basic non-looping run
    cfg_write(3'd0, 16'h1002);
    cfg_write(3'd1, 16'h2001);
    cfg_write(3'd2, 16'hC003);
    cfg_write(3'd4, 16'h0002);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      check_val($sformatf("basic_k%0d", k), 32'(status()), 32'(basic_exp(k, 1'b0)));
      tick();
    end

    // Looping run with a redundant start mid-sequence, then stop
    cfg_write(3'd4, 16'h0006);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      check_val($sformatf("loop_k%0d", k), 32'(status()), 32'(basic_exp(k, 1'b1)));
      if (k == 10) start = 1'b1;
      if (k == 11) start = 1'b0;
      if (k == 30) stop = 1'b1;
      else tick();
    end
    tick();
    stop = 1'b0;
    check_val("stop_status", 32'(status()), 32'h0);
    tick();
    check_val("stop_no_done", 32'(status()), 32'h0);

    // Duration zero behaves as one tick
    cfg_write(3'd0, 16'hF000);
    cfg_write(3'd4, 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check_val($sformatf("dur0_k%0d", k), 32'(status()), (k <= 4) ? 32'h2F : 32'h10);
      tick();
    end

    // Config errors and a step rewrite during a run
    cfg_write(3'd0, 16'h1002);
    cfg_write(3'd1, 16'h2001);
    cfg_write(3'd4, 16'h0001);
    cfg_write(3'd6, 16'hFFFF);
    check_val("err_addr6", 32'(cfg_err), 32'h1);
    tick();
    check_val("err_addr6_clear", 32'(cfg_err), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_write(3'd4, 16'h0004);
    check_val("err_ctrl_busy", 32'(cfg_err), 32'h1);
    cfg_write(3'd1, 16'h8001);
    check_val("step_wr_busy_ok", 32'(cfg_err), 32'h0);
    repeat (6) tick();
    check_val("new_step1_mask", 32'(status()), 32'h28);
    repeat (4) tick();
    check_val("ctrl_unchanged_done", 32'(status()), 32'h10);

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_val("startstop_idle", 32'(status()), 32'h0);
    tick();
    check_val("startstop_idle2", 32'(status()), 32'h0);

    // Asynchronous reset mid-run clears outputs and the table
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_val("pre_reset_run", 32'(status()), 32'h21);
    #2;
    FAB_LOCK = 1'b0;
    #1;
    check_val("async_reset", 32'(status()), 32'h0);
    tick();
    tick();
    FAB_LOCK = 1'b1;
    tick();
    tick();
    check_val("post_reset_idle", 32'(status()), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check_val($sformatf("cleared_tbl_k%0d", k), 32'(status()), (k <= 4) ? 32'h20 : 32'h10);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
Programmable LED pattern sequencer that drives the board's four status LEDs from a small pattern table instead of a fixed toggle counter. A host-side or fabric master loads up to four pattern steps (LED mask plus duration) through a simple register-write port, then starts the sequence. The block steps through the table on a prescaled tick, optionally looping, and reports busy/done. It sits in the fabric clock domain behind the CCC lock signal, alongside other fabric blocks.

Parameters:
TICK_DIV, 50000, fabric clock cycles per sequencer tick (1 ms at 50 MHz); legal range 2..2^20.
DUR_W, 12, width of per-step duration field in ticks.

Ports:
FAB_CLK  input  1  fabric clock; all logic rising-edge.
FAB_LOCK  input  1  reset; asynchronous, active-low (PLL lock low holds block in reset).
cfg_wr  input  1  register write strobe, one cycle per write.
cfg_addr  input  3  register address.
cfg_wdata  input  16  write data.
cfg_err  output  1  one-cycle pulse: rejected write.
start  input  1  start request (level sampled each cycle).
stop  input  1  abort request.
busy  output  1  high while sequence running.
done  output  1  one-cycle pulse on non-looping sequence completion.
LED1..LED4  output  1 each  LED drives, registered.

Behaviour:
- Reset (FAB_LOCK low, async): step table entries 0..3 = 0, ctrl = 0, state IDLE, prescaler = 0, dur_cnt = 0, index = 0, LED1..LED4 = 0, busy = 0, done = 0, cfg_err = 0. Reset mid-run aborts immediately; no done pulse.
- Registers: addr 0..3 = step i: wdata[15:12] = LED mask {LED4,LED3,LED2,LED1}, wdata[DUR_W-1:0] = duration ticks; bits between unused. addr 4 = ctrl: [1:0] last_index, [2] loop_en. Addr 5..7: write ignored, cfg_err pulses next cycle.
- Writes to addr 4 while busy: ignored, cfg_err pulses. Writes to steps while busy: accepted; take effect when that step is next loaded.
- States: IDLE, RUN.
- IDLE -> RUN: start=1 and stop=0 in cycle N. Cycle N+1: busy=1, index=0, LEDs = mask0, dur_cnt = max(dur0,1), prescaler = 0.
- RUN: prescaler counts 0..TICK_DIV-1, wraps; tick = (prescaler == TICK_DIV-1). On tick: if dur_cnt > 1, dur_cnt decrements; else step expires.
- Step expiry (registered, visible next cycle): if index != last_index -> index+1, load its mask and max(dur,1). If index == last_index: loop_en=1 -> index 0, reload step 0; loop_en=0 -> IDLE, LEDs = 0, busy = 0, done = 1 for one cycle.
- Each step is displayed for exactly max(dur,1) * TICK_DIV cycles. Duration 0 is treated as 1.
- start while RUN: ignored (no restart).
- stop in RUN: next cycle IDLE, LEDs = 0, busy = 0, no done pulse. stop and start same cycle: stop wins; remain/go IDLE.
- Step expiry and stop same cycle: stop wins.
- Prescaler and dur_cnt held at 0 in IDLE.
- cfg write and start same cycle: write lands; RUN loads post-write table contents only for steps loaded later; step 0 loaded at start uses pre-write value.

Test Plan:
- Reset: hold FAB_LOCK low mid-run, TICK_DIV=4 -> LEDs=0000, busy=0, done=0 asynchronously; after release stays IDLE.
- Basic run: TICK_DIV=4; steps {mask 0001 dur 2, mask 0010 dur 1, mask 1100 dur 3}; ctrl last=2 loop=0; start at cycle N -> LEDs 0001 for cycles N+1..N+8, 0010 for N+9..N+12, 1100 for N+13..N+24, LEDs 0000, busy 0, done=1 at N+25.
- Loop and stop: same table, loop_en=1 -> after 1100 step returns to 0001 at N+25; assert stop at N+30 -> LEDs 0000, busy 0 at N+31, no done pulse.
- Duration zero: step0 mask 1111 dur 0, last=0, loop=0 -> LEDs 1111 exactly 4 cycles, then done.
- Config errors: write addr 4 while busy -> cfg_err pulse, ctrl unchanged; write addr 6 in IDLE -> cfg_err pulse; write step 1 while running step 0 -> new step 1 mask displayed.
- Simultaneous start+stop in IDLE -> stays IDLE, busy 0; start while RUN -> sequence timing unchanged.
